// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared helpers and constants for the multi-port FIFO and its
//            downstream read serializer.
// Contents : min3      - minimum of three integers
//            popcount  - number of set bits (also used by the FIFO's
//                        request counting)
//            buf_depth - 2**addr_width
//            BUF_DEPTH - default local buffer depth
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int BUF_ADDR_WIDTH_DFLT = 3;
    localparam int BUF_DEPTH           = 1 << BUF_ADDR_WIDTH_DFLT;

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    // Callers zero-extend their vector to 64 bits, which keeps the helper
    // usable for any request width up to 64 ports.
    function automatic int popcount(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n = n + int'(v[i]);
        end
        return n;
    endfunction

    function automatic int buf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serializer_buf.sv
`default_nettype none
// ============================================================================
// Module   : serializer_buf
// Purpose  : Circular buffer with an N-wide ordered push and a single
//            first-word-fall-through pop.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            i_clear          - synchronous clear of pointers and count
//            i_push_mask      - per-lane push strobes (lane 0 = oldest)
//            i_push_data      - lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//            i_pop            - consume the head word (ignored when empty)
//            o_valid/o_data   - head word; o_data is 0 while empty
//            o_count          - occupancy, ADDR_WIDTH+1 bits
// Revision : 1.0 - initial release
// ============================================================================
module serializer_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PUSH   = 2,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_clear,
    input  logic [NUM_PUSH-1:0]            i_push_mask,
    input  logic [NUM_PUSH*DATA_WIDTH-1:0] i_push_data,
    input  logic                           i_pop,
    output logic                           o_valid,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [ADDR_WIDTH:0]            o_count
);

    localparam int               c_DEPTH = buf_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH-1:0] w_slot_addr [NUM_PUSH];
    logic [ADDR_WIDTH:0]   w_push_cnt;
    logic                  w_pop;

    // Active lanes are packed densely from wr_ptr upward in lane order, so a
    // missing lane in the middle leaves no hole in the buffer.
    always_comb begin
        w_push_cnt = '0;
        for (int i = 0; i < NUM_PUSH; i++) begin
            w_slot_addr[i] = r_wr_ptr[ADDR_WIDTH-1:0] + w_push_cnt[ADDR_WIDTH-1:0];
            if (i_push_mask[i]) begin
                w_push_cnt = w_push_cnt + c_ONE;
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign w_pop   = i_pop && o_valid;
    assign o_data  = o_valid ? r_mem[r_rd_ptr[ADDR_WIDTH-1:0]] : '0;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (!i_clear) begin
            for (int i = 0; i < NUM_PUSH; i++) begin
                if (i_push_mask[i]) begin
                    r_mem[w_slot_addr[i]] <= i_push_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_cnt;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            r_count <= r_count + w_push_cnt - {{ADDR_WIDTH{1'b0}}, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_port_read_serializer.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_read_serializer
// Purpose  : Drains a multi-ported FIFO with up to N reads per cycle and
//            re-emits the words as one in-order valid/ready stream.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            fifo_rd_en[N]               - contiguous read requests, bit 0 oldest
//            fifo_rd_data/fifo_rd_valid  - FIFO returns, one cycle after request
//            fifo_data_count             - FIFO occupancy
//            flush                       - drop buffer and in-flight returns
//            m_valid/m_data/m_ready      - FWFT output stream
//            buf_count                   - local buffer occupancy
//            protocol_err                - sticky, unexpected/missing return
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_read_serializer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int NUM_READ_PORTS  = 2,
    parameter int BUF_ADDR_WIDTH  = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    output logic [NUM_READ_PORTS-1:0]            fifo_rd_en,
    input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] fifo_rd_data,
    input  logic [NUM_READ_PORTS-1:0]            fifo_rd_valid,
    input  logic [FIFO_ADDR_WIDTH:0]             fifo_data_count,
    input  logic                                 flush,
    output logic                                 m_valid,
    output logic [DATA_WIDTH-1:0]                m_data,
    input  logic                                 m_ready,
    output logic [BUF_ADDR_WIDTH:0]              buf_count,
    output logic                                 protocol_err
);

    localparam int c_DEPTH = buf_depth(BUF_ADDR_WIDTH);

    logic [NUM_READ_PORTS-1:0] r_expect_mask;
    logic                      r_flush_q;
    logic                      r_protocol_err;
    logic [NUM_READ_PORTS-1:0] w_rd_en;
    logic [NUM_READ_PORTS-1:0] w_push_mask;
    logic                      w_err;
    int                        w_inflight;
    int                        w_free;
    int                        w_issue;

    // Credit: space not yet claimed by stored words or by requests whose
    // data is still on its way back. Only registered state feeds this, so
    // m_ready never reaches fifo_rd_en combinationally.
    always_comb begin
        w_inflight = popcount(64'(r_expect_mask));
        w_free     = c_DEPTH - int'(buf_count) - w_inflight;
        w_issue    = min3(NUM_READ_PORTS, int'(fifo_data_count), w_free);
        if (flush || !rst_n) begin
            w_issue = 0;
        end
        for (int i = 0; i < NUM_READ_PORTS; i++) begin
            w_rd_en[i] = (i < w_issue);
        end
    end

    assign fifo_rd_en = w_rd_en;

    // Unrequested lanes are dropped; a missing expected lane simply never
    // pushes, which releases its credit. The cycle right after a flush
    // carries returns of cancelled requests and is not checked.
    assign w_push_mask = fifo_rd_valid & r_expect_mask;
    assign w_err       = !r_flush_q && (fifo_rd_valid != r_expect_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expect_mask  <= '0;
            r_flush_q      <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_expect_mask <= flush ? '0 : w_rd_en;
            r_flush_q     <= flush;
            if (w_err) begin
                r_protocol_err <= 1'b1;
            end
        end
    end

    assign protocol_err = r_protocol_err;

    serializer_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_PUSH   (NUM_READ_PORTS),
        .ADDR_WIDTH (BUF_ADDR_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (flush),
        .i_push_mask (w_push_mask),
        .i_push_data (fifo_rd_data),
        .i_pop       (m_ready),
        .o_valid     (m_valid),
        .o_data      (m_data),
        .o_count     (buf_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_multi_port_read_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_port_read_serializer
// Purpose  : Self-checking bench for multi_port_read_serializer. A FIFO model
//            answers read requests one cycle later; each returned word is
//            queued as expected output and a monitor checks the stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_port_read_serializer;

    localparam int DW  = 32;
    localparam int FAW = 4;
    localparam int N   = 2;
    localparam int BAW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    fifo_rd_en;
    logic [N*DW-1:0] fifo_rd_data = '0;
    logic [N-1:0]    fifo_rd_valid = '0;
    logic [FAW:0]    fifo_data_count = '0;
    logic            flush = 1'b0;
    logic            m_valid;
    logic [DW-1:0]   m_data;
    logic            m_ready = 1'b0;
    logic [BAW:0]    buf_count;
    logic            protocol_err;

    multi_port_read_serializer #(
        .DATA_WIDTH      (DW),
        .FIFO_ADDR_WIDTH (FAW),
        .NUM_READ_PORTS  (N),
        .BUF_ADDR_WIDTH  (BAW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_rd_valid   (fifo_rd_valid),
        .fifo_data_count (fifo_data_count),
        .flush           (flush),
        .m_valid         (m_valid),
        .m_data          (m_data),
        .m_ready         (m_ready),
        .buf_count       (buf_count),
        .protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] sb_q[$];
    int            n_tests  = 0;
    int            n_fail   = 0;
    int            n_out    = 0;
    int            n_popped = 0;
    int            n_bad_en = 0;
    logic          inj_en    = 1'b0;
    logic [N-1:0]  inj_valid = '0;
    logic [N-1:0]  last_en   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic upd_count();
        fifo_data_count = (model_q.size() > 16) ? 5'd16 : 5'(model_q.size());
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            model_q.push_back(base + DW'(i));
        end
        upd_count();
        #1;
    endtask

    // One clock: sample the request before the edge, answer it after the
    // edge (registered FIFO read), and return 2 time units past the edge.
    task automatic step();
        logic [N-1:0] en_q;
        logic [DW-1:0] w;
        @(negedge clk);
        en_q    = fifo_rd_en;
        last_en = en_q;
        if (!(en_q == 2'b00 || en_q == 2'b01 || en_q == 2'b11)) begin
            n_bad_en++;
        end
        @(posedge clk);
        #1;
        fifo_rd_data = '0;
        if (inj_en) begin
            fifo_rd_valid = inj_valid;
            fifo_rd_data  = {$urandom, $urandom};
            inj_en        = 1'b0;
        end else begin
            fifo_rd_valid = en_q;
            for (int i = 0; i < N; i++) begin
                if (en_q[i] && model_q.size() != 0) begin
                    w = model_q.pop_front();
                    fifo_rd_data[i*DW +: DW] = w;
                    sb_q.push_back(w);
                    n_popped++;
                end
            end
        end
        upd_count();
        #1;
    endtask

    task automatic drain(input int bound, input bit rand_ready);
        int cyc;
        cyc = 0;
        while ((model_q.size() != 0 || sb_q.size() != 0) && cyc < bound) begin
            if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        check("drain_done", 64'(model_q.size() + sb_q.size()), 64'd0);
    endtask

    // Output monitor: a transfer happens at the next edge when valid and
    // ready are both high at the falling edge.
    always @(negedge clk) begin
        logic [DW-1:0] exp_w;
        if (rst_n && !flush && m_valid && m_ready) begin
            n_tests++;
            n_out++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no word", m_data);
            end else begin
                exp_w = sb_q.pop_front();
                if (m_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL sb_data: got 0x%0h, expected 0x%0h", m_data, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, p0, over, gaps, bc;

        // ---------------- reset state ----------------
        push_words(16, 32'h1);
        #11;
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_buf_count", 64'(buf_count), 64'd0);
        check("rst_protocol_err", 64'(protocol_err), 64'd0);

        // ---------------- order preserved ----------------
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        #1;
        check("order_rd_en_c0", 64'(fifo_rd_en), 64'h3);
        step();
        check("order_valid_c1", 64'(m_valid), 64'd0);
        step();
        check("order_valid_c2", 64'(m_valid), 64'd1);
        check("order_data_c2", 64'(m_data), 64'h1);
        gaps = 0;
        for (int c = 3; c <= 17; c++) begin
            step();
            if (!m_valid) gaps++;
        end
        check("order_gaps", 64'(gaps), 64'd0);
        step();
        check("order_valid_c18", 64'(m_valid), 64'd0);
        check("order_count", 64'(n_out), 64'd16);

        // ---------------- partial availability ----------------
        for (int j = 0; j < 3; j++) begin
            push_words(1, 32'hA0 + DW'(j));
            check("partial_en", 64'(fifo_rd_en), 64'h1);
            step();
            check("partial_en_next", 64'(fifo_rd_en), 64'h0);
            step();
            check("partial_valid", 64'(m_valid), 64'd1);
            check("partial_data", 64'(m_data), 64'hA0 + 64'(j));
            step();
        end

        // ---------------- backpressure ----------------
        m_ready = 1'b0;
        o0 = n_out;
        p0 = n_popped;
        over = 0;
        push_words(20, 32'h100);
        for (int c = 0; c < 12; c++) begin
            step();
            if (int'(buf_count) + $countones(last_en) + $countones(fifo_rd_en) > 8) over++;
        end
        check("bp_buf_count", 64'(buf_count), 64'd8);
        check("bp_rd_en_stop", 64'(fifo_rd_en), 64'd0);
        check("bp_requested", 64'(n_popped - p0), 64'd8);
        check("bp_over_credit", 64'(over), 64'd0);
        m_ready = 1'b1;
        drain(100, 1'b0);
        check("bp_out_count", 64'(n_out - o0), 64'd20);

        // ---------------- wrap-around with random ready ----------------
        o0 = n_out;
        push_words(100, 32'h1000);
        drain(2000, 1'b1);
        check("wrap_out_count", 64'(n_out - o0), 64'd100);
        check("wrap_protocol_err", 64'(protocol_err), 64'd0);

        // ---------------- flush mid-stream ----------------
        m_ready = 1'b0;
        step();
        push_words(5, 32'h200);
        for (int c = 0; c < 20 && buf_count != 5; c++) step();
        check("flush_pre_buf", 64'(buf_count), 64'd5);
        push_words(2, 32'h210);
        check("flush_pre_en", 64'(fifo_rd_en), 64'h3);
        step();
        check("flush_inflight_buf", 64'(buf_count), 64'd5);
        push_words(1, 32'h220);
        flush     = 1'b1;
        inj_en    = 1'b1;
        inj_valid = 2'b11;
        sb_q.delete();
        #1;
        check("flush_rd_en", 64'(fifo_rd_en), 64'd0);
        step();
        flush = 1'b0;
        check("flush_buf_count", 64'(buf_count), 64'd0);
        check("flush_m_valid", 64'(m_valid), 64'd0);
        step();
        check("flush_late_err", 64'(protocol_err), 64'd0);
        check("flush_late_buf", 64'(buf_count), 64'd0);
        m_ready = 1'b1;
        drain(50, 1'b0);

        // ---------------- protocol error ----------------
        m_ready = 1'b0;
        push_words(3, 32'h300);
        for (int c = 0; c < 4; c++) step();
        bc = int'(buf_count);
        check("err_pre_buf", 64'(bc), 64'd3);
        check("err_pre", 64'(protocol_err), 64'd0);
        inj_en    = 1'b1;
        inj_valid = 2'b10;
        step();
        check("err_same_cycle", 64'(protocol_err), 64'd0);
        step();
        check("err_set", 64'(protocol_err), 64'd1);
        check("err_buf_unchanged", 64'(buf_count), 64'd3);
        m_ready = 1'b1;
        drain(50, 1'b0);
        check("err_sticky", 64'(protocol_err), 64'd1);

        // ---------------- reset mid-burst ----------------
        push_words(10, 32'h400);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mrst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("mrst_m_valid", 64'(m_valid), 64'd0);
        check("mrst_m_data", 64'(m_data), 64'd0);
        check("mrst_buf_count", 64'(buf_count), 64'd0);
        check("mrst_protocol_err", 64'(protocol_err), 64'd0);
        model_q.delete();
        sb_q.delete();
        fifo_rd_valid = '0;
        upd_count();
        step();
        step();
        rst_n = 1'b1;
        o0 = n_out;
        push_words(4, 32'h500);
        drain(50, 1'b0);
        check("post_rst_out_count", 64'(n_out - o0), 64'd4);
        check("rd_en_contiguous", 64'(n_bad_en), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
